// File: rtl/matmul_pkg.sv
// Shared types and memory-map constants for the matmul input path.
package matmul_pkg;

    // Memory map of the input matrix and width of the RAM read port.
    localparam logic [31:0] INPUT_MAT_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] MEM_ADDR_INCR       = 32'h0000_0008;
    localparam int unsigned MEM_PORT_WIDTH      = 64;

    typedef enum logic [2:0] {
        IDLE,
        MEM_RD,
        MEM_RD_WAIT,
        STREAM,
        DRAIN,
        DONE
    } loader_state_e;

    // Byte address of input-matrix row 'row'.
    function automatic logic [31:0] row_addr(input logic [31:0] row);
        return INPUT_MAT_BASE_ADDR + row * MEM_ADDR_INCR;
    endfunction

endpackage

// File: rtl/matmul_input_loader_skew_delay_line.sv
// Triangular skew line: lane i is delayed by i clocks, lane 0 passes straight through.
// All stages hold their contents while en is low.
module skew_delay_line #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [ROWS*WORD_SIZE-1:0] in_data,
    input  logic [ROWS-1:0]           in_valid,
    output logic [ROWS*WORD_SIZE-1:0] out_data,
    output logic [ROWS-1:0]           out_valid
);

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign out_data[0 +: WORD_SIZE] = in_data[0 +: WORD_SIZE];
            assign out_valid[0]             = in_valid[0];
        end else begin : g_dly
            logic [WORD_SIZE-1:0] data_q  [i];
            logic [i-1:0]         valid_q;

            // i-deep shift register for lane i, frozen while en is low.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < i; j++) begin
                        data_q[j] <= '0;
                    end
                    valid_q <= '0;
                end else if (en) begin
                    data_q[0]  <= in_data[i*WORD_SIZE +: WORD_SIZE];
                    valid_q[0] <= in_valid[i];
                    for (int j = 1; j < i; j++) begin
                        data_q[j]  <= data_q[j-1];
                        valid_q[j] <= valid_q[j-1];
                    end
                end
            end

            assign out_data[i*WORD_SIZE +: WORD_SIZE] = data_q[i-1];
            assign out_valid[i]                       = valid_q[i-1];
        end
    end

endmodule

// File: rtl/matmul_input_loader.sv
// Input loader: reads an input matrix row by row from RAM into a local buffer, then streams
// one vector per HOLD_CYCLES clocks into the systolic array through a lane skew line.
module matmul_input_loader
    import matmul_pkg::*;
#(
    parameter int unsigned ROWS               = 4,
    parameter int unsigned MAT_ROWS           = 4,
    parameter int unsigned WORD_SIZE          = 16,
    parameter int unsigned MEM_ACCESS_LATENCY = 2,
    parameter int unsigned HOLD_CYCLES        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    output logic [31:0]               mem_rd_addr,
    output logic                      mem_rd_en,
    input  logic [MEM_PORT_WIDTH-1:0] mem_rd_data,
    output logic [ROWS*WORD_SIZE-1:0] sa_input_bus,
    output logic [ROWS-1:0]           sa_input_valid,
    output logic                      busy,
    output logic                      load_done
);

    localparam int unsigned BUS_W  = ROWS * WORD_SIZE;
    localparam int unsigned ROW_W  = $clog2(MAT_ROWS) + 1;
    localparam int unsigned IDX_W  = (MAT_ROWS > 1) ? $clog2(MAT_ROWS) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned DLY_W  = $clog2(MEM_ACCESS_LATENCY) + 1;
    localparam int unsigned DRN_W  = $clog2(ROWS) + 1;

    loader_state_e     state_q;
    logic [ROW_W-1:0]  row_idx_q;
    logic [ROW_W-1:0]  vec_idx_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [DLY_W-1:0]  delay_q;
    logic [DRN_W-1:0]  drain_cnt_q;
    logic [BUS_W-1:0]  row_buf_q [MAT_ROWS];

    // Lane-0 stage: the vector slot currently injected, before skewing.
    logic [BUS_W-1:0]  stage_data_q;
    logic [ROWS-1:0]   stage_valid_q;
    logic              skew_en;

    // Stall only freezes the array-facing path; RAM reads always run to completion.
    assign skew_en = !(stall && (state_q == STREAM || state_q == DRAIN));

    // Loader FSM with buffer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_idx_q     <= '0;
            vec_idx_q     <= '0;
            hold_cnt_q    <= '0;
            delay_q       <= '0;
            drain_cnt_q   <= '0;
            stage_data_q  <= '0;
            stage_valid_q <= '0;
            mem_rd_addr   <= '0;
            mem_rd_en     <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            for (int r = 0; r < MAT_ROWS; r++) begin
                row_buf_q[r] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= MEM_RD;
                        row_idx_q   <= '0;
                        mem_rd_addr <= row_addr(32'd0);
                        mem_rd_en   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                MEM_RD: begin
                    mem_rd_en <= 1'b0;
                    delay_q   <= DLY_W'(MEM_ACCESS_LATENCY - 1);
                    state_q   <= MEM_RD_WAIT;
                end
                MEM_RD_WAIT: begin
                    if (delay_q != '0) begin
                        delay_q <= delay_q - 1'b1;
                    end else begin
                        row_buf_q[row_idx_q[IDX_W-1:0]] <= mem_rd_data[BUS_W-1:0];
                        row_idx_q <= row_idx_q + 1'b1;
                        if (row_idx_q == ROW_W'(MAT_ROWS - 1)) begin
                            // Preload vector 0 so it is on the lanes in the first STREAM clock.
                            state_q       <= STREAM;
                            vec_idx_q     <= '0;
                            hold_cnt_q    <= '0;
                            stage_valid_q <= '1;
                            stage_data_q  <= (row_idx_q == '0) ? mem_rd_data[BUS_W-1:0]
                                                               : row_buf_q[0];
                        end else begin
                            state_q     <= MEM_RD;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= row_addr(32'(row_idx_q + 1'b1));
                        end
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                            hold_cnt_q <= '0;
                            if (vec_idx_q == ROW_W'(MAT_ROWS - 1)) begin
                                stage_data_q  <= '0;
                                stage_valid_q <= '0;
                                drain_cnt_q   <= '0;
                                if (ROWS > 1) begin
                                    state_q <= DRAIN;
                                end else begin
                                    state_q   <= DONE;
                                    load_done <= 1'b1;
                                end
                            end else begin
                                vec_idx_q    <= vec_idx_q + 1'b1;
                                stage_data_q <= row_buf_q[IDX_W'(vec_idx_q + 1'b1)];
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt_q == DRN_W'(ROWS - 2)) begin
                            state_q   <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    load_done <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    skew_delay_line #(
        .ROWS      (ROWS),
        .WORD_SIZE (WORD_SIZE)
    ) u_skew (
        .clk       (clk),
        .rst       (rst),
        .en        (skew_en),
        .in_data   (stage_data_q),
        .in_valid  (stage_valid_q),
        .out_data  (sa_input_bus),
        .out_valid (sa_input_valid)
    );

endmodule

// File: tb/tb_matmul_input_loader.sv
// Bench for matmul_input_loader: two instances (default timing, and latency/hold of 1) share
// stimulus; a timeline model predicts every output on every clock.
module tb_matmul_input_loader;
    import matmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] addr0, addr1;
    logic        en0, en1;
    logic [63:0] rdata0, rdata1;
    logic [63:0] bus0, bus1;
    logic [3:0]  val0, val1;
    logic        busy0, busy1, done0, done1;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [2][4][4];
    int lat_p [2] = '{2, 1};
    int hold_p [2] = '{2, 1};

    always #5 clk = ~clk;

    matmul_input_loader #(
        .ROWS(4), .MAT_ROWS(4), .WORD_SIZE(16), .MEM_ACCESS_LATENCY(2), .HOLD_CYCLES(2)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mem_rd_addr(addr0), .mem_rd_en(en0), .mem_rd_data(rdata0),
        .sa_input_bus(bus0), .sa_input_valid(val0), .busy(busy0), .load_done(done0)
    );

    matmul_input_loader #(
        .ROWS(4), .MAT_ROWS(4), .WORD_SIZE(16), .MEM_ACCESS_LATENCY(1), .HOLD_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mem_rd_addr(addr1), .mem_rd_en(en1), .mem_rd_data(rdata1),
        .sa_input_bus(bus1), .sa_input_valid(val1), .busy(busy1), .load_done(done1)
    );

    // ---------------- RAM responder ----------------
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    function automatic logic [63:0] ram_read(input int k, input logic en, input logic [31:0] a);
        int r;
        if (!en || a < INPUT_MAT_BASE_ADDR) return JUNK;
        r = int'((a - INPUT_MAT_BASE_ADDR) / MEM_ADDR_INCR);
        if (r > 3) return JUNK;
        return {mem[k][r][3], mem[k][r][2], mem[k][r][1], mem[k][r][0]};
    endfunction

    logic [63:0] p0_d [2] = '{JUNK, JUNK};
    logic [63:0] p1_d = JUNK;

    always @(posedge clk) begin
        p0_d[0] <= ram_read(0, en0, addr0);
        p0_d[1] <= p0_d[0];
        p1_d    <= ram_read(1, en1, addr1);
    end
    assign rdata0 = p0_d[1];
    assign rdata1 = p1_d;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Lane j shows stream element p-j; element e belongs to vector e/hold.
    function automatic void exp_stream(input int k, input int pp,
                                       output logic [63:0] eb, output logic [3:0] ev);
        eb = '0;
        ev = '0;
        for (int j = 0; j < 4; j++) begin
            int e;
            e = pp - j;
            if (e >= 0 && e < 4 * hold_p[k]) begin
                eb[j*16 +: 16] = mem[k][e / hold_p[k]][j];
                ev[j] = 1'b1;
            end
        end
    endfunction

    // ---------------- timeline model + compare ----------------
    // Phase: 0 idle, 1 reading, 2 streaming/draining, 3 done.
    int m_ph [2] = '{0, 0};
    int m_t  [2] = '{0, 0};
    int m_p  [2] = '{0, 0};
    logic [63:0] e_bus;
    logic [3:0]  e_val;
    logic        e_en, e_busy, e_done;
    logic [31:0] e_addr;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_bus = '0; e_val = '0; e_en = 1'b0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0;
            if (!rst) begin
                m_ph[k] = 0;
            end else begin
                case (m_ph[k])
                    1: begin
                        e_busy = 1'b1;
                        e_en   = (m_t[k] % (1 + lat_p[k])) == 0;
                        e_addr = INPUT_MAT_BASE_ADDR
                                 + 32'(m_t[k] / (1 + lat_p[k])) * MEM_ADDR_INCR;
                    end
                    2: begin
                        e_busy = 1'b1;
                        exp_stream(k, m_p[k], e_bus, e_val);
                    end
                    3: begin
                        e_busy = 1'b1;
                        e_done = 1'b1;
                        exp_stream(k, 4 * hold_p[k] + 3, e_bus, e_val);
                    end
                    default: ;
                endcase
            end
            check($sformatf("i%0d sa_input_bus", k), (k == 0) ? bus0 : bus1, e_bus);
            check($sformatf("i%0d sa_input_valid", k), 64'((k == 0) ? val0 : val1), 64'(e_val));
            check($sformatf("i%0d mem_rd_en", k), 64'((k == 0) ? en0 : en1), 64'(e_en));
            check($sformatf("i%0d busy", k), 64'((k == 0) ? busy0 : busy1), 64'(e_busy));
            check($sformatf("i%0d load_done", k), 64'((k == 0) ? done0 : done1), 64'(e_done));
            if (e_en || !rst)
                check($sformatf("i%0d mem_rd_addr", k), 64'((k == 0) ? addr0 : addr1),
                      64'(e_addr));
            if (rst) begin
                case (m_ph[k])
                    0: if (start) begin m_ph[k] = 1; m_t[k] = 0; end
                    1: begin
                        m_t[k]++;
                        if (m_t[k] == 4 * (1 + lat_p[k])) begin m_ph[k] = 2; m_p[k] = 0; end
                    end
                    2: begin
                        if (!stall) m_p[k]++;
                        if (m_p[k] == 4 * hold_p[k] + 3) m_ph[k] = 3;
                    end
                    default: m_ph[k] = 0;
                endcase
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic [3:0]  obs_val [256];
    logic [15:0] obs_l0  [256];
    logic [15:0] obs_l3  [256];

    // One start pulse; stall held for cycles [stall_at, stall_at+stall_len) after start.
    task automatic run_load(input int stall_at, input int stall_len,
                            output int d0, output int d1, output int pulses,
                            output int gap, output logic [31:0] first_addr);
        int last;
        d0 = -1; d1 = -1; pulses = 0; gap = -1; last = -1; first_addr = '1;
        start = 1'b1;
        for (int c = 0; c < 200 && (d0 < 0 || d1 < 0); c++) begin
            stall = (c >= stall_at && c < stall_at + stall_len);
            @(negedge clk);
            obs_val[c] = val0;
            obs_l0[c]  = bus0[15:0];
            obs_l3[c]  = bus0[63:48];
            if (en0) begin
                if (pulses == 0) first_addr = addr0;
                if (pulses == 1) gap = c - last;
                last = c;
                pulses++;
            end
            if (done0 && d0 < 0) d0 = c;
            if (done1 && d1 < 0) d1 = c;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        stall = 1'b0;
    endtask

    task automatic randomize_mem();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 4; r++)
                for (int i = 0; i < 4; i++)
                    mem[k][r][i] = 16'($urandom);
        mem[0][1][2] = 16'h8000;
        mem[1][0][0] = 16'h8000;
        mem[1][3][3] = 16'hFFFF;
        mem[0][3][1] = 16'hFFFF;
    endtask

    initial begin
        int d0, d1, np, gap, nd, rd_after;
        int dcyc [2];
        logic [31:0] fa;

        randomize_mem();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++)
                mem[0][r][i] = 16'(r * 4 + i);

        // Reset state.
        @(negedge clk);
        check("reset busy", 64'(busy0), 64'd0);
        check("reset mem_rd_addr", 64'(addr0), 64'd0);
        check("reset sa_input_valid", 64'(val0), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Single load: read pulses, latency and skew.
        run_load(-100, 0, d0, d1, np, gap, fa);
        check("t1 load_done latency i0", 64'(d0), 64'd24);
        check("t1 load_done latency i1", 64'(d1), 64'd16);
        check("t1 read pulses", 64'(np), 64'd4);
        check("t1 read spacing", 64'(gap), 64'd3);
        check("t1 first read addr", 64'(fa), 64'(INPUT_MAT_BASE_ADDR));
        check("t2 valid ramp c13", 64'(obs_val[13]), 64'h1);
        check("t2 valid ramp c14", 64'(obs_val[14]), 64'h3);
        check("t2 valid ramp c15", 64'(obs_val[15]), 64'h7);
        check("t2 valid ramp c16", 64'(obs_val[16]), 64'hF);
        check("t2 lane0 vec0", 64'(obs_l0[13]), 64'd0);
        check("t2 lane0 vec1", 64'(obs_l0[15]), 64'd4);
        check("t2 lane3 vec0", 64'(obs_l3[16]), 64'd3);
        check("t2 lane3 vec3", 64'(obs_l3[22]), 64'd15);

        // Stall for three clocks mid-stream.
        run_load(15, 3, d0, d1, np, gap, fa);
        check("t3 load_done latency", 64'(d0), 64'd27);
        check("t3 frozen valid c18", 64'(obs_val[18]), 64'h7);
        check("t3 lane0 held c19", 64'(obs_l0[19]), 64'd4);
        check("t3 lane0 resumes c20", 64'(obs_l0[20]), 64'd8);

        // Reset during the wait for row 2, then a fresh load.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t4 async busy", 64'(busy0), 64'd0);
        check("t4 async mem_rd_en", 64'(en0), 64'd0);
        check("t4 async valid", 64'(val0), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        run_load(-100, 0, d0, d1, np, gap, fa);
        check("t4 restart addr", 64'(fa), 64'(INPUT_MAT_BASE_ADDR));
        check("t4 restart latency", 64'(d0), 64'd24);

        // Start held high.
        start = 1'b1;
        nd = 0; dcyc = '{-1, -1}; rd_after = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done0) begin
                if (nd < 2) dcyc[nd] = c;
                nd++;
            end
            if (en0 && nd == 1 && rd_after < 0) rd_after = c;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("t5 load count", 64'(nd), 64'd2);
        check("t5 first done", 64'(dcyc[0]), 64'd24);
        check("t5 second done", 64'(dcyc[1]), 64'd49);
        check("t5 reload read", 64'(rd_after), 64'd26);
        rst = 1'b0;
        randomize_mem();
        @(posedge clk); #1 rst = 1'b1;

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                randomize_mem();
            end else begin
                rst = 1'b1;
            end
            start = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
